// File: rtl/pipearch_dma_read_mc.sv
// Multi-channel DMA read engine.
// Several independent read streams share one memory request port through a round-robin arbiter.
// Each channel has a reorder buffer, so out-of-order responses leave the channel in request order.
module pipearch_dma_read_mc #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned ADDR_W       = 42,
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned LOG2_DEPTH   = 6,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned TAG_W        = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CHANNELS-1:0]        cmd_valid,
  output logic [NUM_CHANNELS-1:0]        cmd_ready,
  input  logic [NUM_CHANNELS*ADDR_W-1:0] cmd_addr,
  input  logic [NUM_CHANNELS*32-1:0]     cmd_length,
  input  logic [NUM_CHANNELS*32-1:0]     cmd_stride,
  input  logic [NUM_CHANNELS-1:0]        cmd_multiline,
  output logic                           mem_req_valid,
  output logic [ADDR_W-1:0]              mem_req_addr,
  output logic [1:0]                     mem_req_len,
  output logic [TAG_W-1:0]               mem_req_tag,
  input  logic                           mem_req_almfull,
  input  logic                           mem_rsp_valid,
  input  logic [TAG_W-1:0]               mem_rsp_tag,
  input  logic [1:0]                     mem_rsp_cl_num,
  input  logic [DATA_W-1:0]              mem_rsp_data,
  output logic [NUM_CHANNELS-1:0]        out_valid,
  input  logic [NUM_CHANNELS-1:0]        out_ready,
  output logic [NUM_CHANNELS*DATA_W-1:0] out_data,
  output logic [NUM_CHANNELS-1:0]        status_idle,
  output logic [NUM_CHANNELS-1:0]        status_done
);

  localparam int unsigned DEPTH   = 2 ** LOG2_DEPTH;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  st_q      [NUM_CHANNELS];
  state_e                  st_d      [NUM_CHANNELS];
  logic [ADDR_W-1:0]       addr_q    [NUM_CHANNELS];
  logic [31:0]             len_q     [NUM_CHANNELS];
  logic [31:0]             stride_q  [NUM_CHANNELS];
  logic                    multi_q   [NUM_CHANNELS];
  logic [31:0]             req_cnt_q [NUM_CHANNELS];
  logic [31:0]             cons_q    [NUM_CHANNELS];
  logic [LOG2_DEPTH-1:0]   head_q    [NUM_CHANNELS];
  logic [DEPTH-1:0]        vld_q     [NUM_CHANNELS];
  logic [DEPTH-1:0]        vld_d     [NUM_CHANNELS];
  logic [DATA_W-1:0]       rob_q     [NUM_CHANNELS][DEPTH];

  logic [31:0]             remaining [NUM_CHANNELS];
  logic [31:0]             free_cnt  [NUM_CHANNELS];
  logic [2:0]              lines     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] elig;
  logic [NUM_CHANNELS-1:0] pop;

  logic                    gnt_valid;
  logic [CH_W-1:0]         gnt_ch;
  logic [CH_W-1:0]         rr_idx;
  logic [CH_W-1:0]         rr_ptr_q;

  logic [CH_W-1:0]         rsp_ch;
  logic [LOG2_DEPTH-1:0]   rsp_slot;
  logic                    rsp_we;
  logic                    unused_tag_bits;

  assign rsp_ch          = mem_rsp_tag[CH_W+LOG2_DEPTH-1:LOG2_DEPTH];
  assign rsp_slot        = mem_rsp_tag[LOG2_DEPTH-1:0] + LOG2_DEPTH'(mem_rsp_cl_num);
  assign rsp_we          = mem_rsp_valid && (st_q[rsp_ch] == StRun);
  assign unused_tag_bits = ^mem_rsp_tag[TAG_W-1:CH_W+LOG2_DEPTH];

  // Burst size per channel: largest of 4/2/1 lines allowed by alignment, remaining length and credit.
  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      remaining[c] = len_q[c] - req_cnt_q[c];
      free_cnt[c]  = DEPTH_W - (req_cnt_q[c] - cons_q[c]);
      lines[c]     = 3'd0;
      if (st_q[c] == StRun) begin
        if (multi_q[c] && stride_q[c] == 32'd1 && addr_q[c][1:0] == 2'b00 &&
            remaining[c] >= 32'd4 && free_cnt[c] >= 32'd4) begin
          lines[c] = 3'd4;
        end else if (multi_q[c] && stride_q[c] == 32'd1 && !addr_q[c][0] &&
                     remaining[c] >= 32'd2 && free_cnt[c] >= 32'd2) begin
          lines[c] = 3'd2;
        end else if (remaining[c] >= 32'd1 && free_cnt[c] >= 32'd1) begin
          lines[c] = 3'd1;
        end
      end
      elig[c] = (lines[c] != 3'd0);
    end
  end

  // Round-robin pick starting at the channel after the last grant; almost-full blocks all grants.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    rr_idx    = '0;
    if (!mem_req_almfull) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        rr_idx = rr_ptr_q + CH_W'(i);
        if (!gnt_valid && elig[rr_idx]) begin
          gnt_valid = 1'b1;
          gnt_ch    = rr_idx;
        end
      end
    end
  end

  // Head-of-buffer output, pop detection and next valid bits (pop clear and response set).
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    pop       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      out_valid[c]                  = vld_q[c][head_q[c]];
      pop[c]                        = out_valid[c] & out_ready[c];
      out_data[c*DATA_W +: DATA_W]  = rob_q[c][head_q[c]];
      vld_d[c]                      = vld_q[c];
      if (pop[c]) vld_d[c][head_q[c]] = 1'b0;
      if (rsp_we && rsp_ch == CH_W'(c)) vld_d[c][rsp_slot] = 1'b1;
    end
  end

  // Channel FSM next state and status outputs.
  always_comb begin
    cmd_ready   = '0;
    status_idle = '0;
    status_done = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      st_d[c]        = st_q[c];
      cmd_ready[c]   = (st_q[c] == StIdle);
      status_idle[c] = (st_q[c] == StIdle);
      status_done[c] = (st_q[c] == StDone);
      unique case (st_q[c])
        StIdle: begin
          if (cmd_valid[c]) begin
            st_d[c] = (cmd_length[c*32 +: 32] == 32'd0) ? StDone : StRun;
          end
        end
        StRun:   if (cons_q[c] == len_q[c]) st_d[c] = StDone;
        StDone:  st_d[c] = StIdle;
        default: st_d[c] = StIdle;
      endcase
    end
  end

  // Channel state, counters, address walk and reorder-buffer valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        st_q[c]      <= StIdle;
        addr_q[c]    <= '0;
        len_q[c]     <= '0;
        stride_q[c]  <= '0;
        multi_q[c]   <= 1'b0;
        req_cnt_q[c] <= '0;
        cons_q[c]    <= '0;
        head_q[c]    <= '0;
        vld_q[c]     <= '0;
      end
    end else begin
      if (gnt_valid) rr_ptr_q <= gnt_ch + CH_W'(1);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        st_q[c] <= st_d[c];
        if (st_q[c] == StIdle && cmd_valid[c]) begin
          addr_q[c]    <= cmd_addr[c*ADDR_W +: ADDR_W];
          len_q[c]     <= cmd_length[c*32 +: 32];
          stride_q[c]  <= cmd_stride[c*32 +: 32];
          multi_q[c]   <= cmd_multiline[c];
          req_cnt_q[c] <= '0;
          cons_q[c]    <= '0;
          head_q[c]    <= '0;
          vld_q[c]     <= '0;
        end else begin
          if (gnt_valid && gnt_ch == CH_W'(c)) begin
            addr_q[c]    <= addr_q[c] + ADDR_W'(stride_q[c]) * ADDR_W'(lines[c]);
            req_cnt_q[c] <= req_cnt_q[c] + 32'(lines[c]);
          end
          if (pop[c]) begin
            cons_q[c] <= cons_q[c] + 32'd1;
            head_q[c] <= head_q[c] + LOG2_DEPTH'(1);
          end
          vld_q[c] <= vld_d[c];
        end
      end
    end
  end

  // Reorder-buffer data storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (rsp_we) rob_q[rsp_ch][rsp_slot] <= mem_rsp_data;
  end

  // Registered memory request: tag carries channel and the base slot of the burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_len   <= 2'b00;
      mem_req_tag   <= '0;
    end else begin
      mem_req_valid <= gnt_valid;
      if (gnt_valid) begin
        mem_req_addr <= addr_q[gnt_ch];
        mem_req_len  <= (lines[gnt_ch] == 3'd4) ? 2'b11 :
                        (lines[gnt_ch] == 3'd2) ? 2'b01 : 2'b00;
        mem_req_tag  <= TAG_W'({gnt_ch, req_cnt_q[gnt_ch][LOG2_DEPTH-1:0]});
      end
    end
  end

endmodule

// File: tb/tb_pipearch_dma_read_mc.sv
// Directed bench for pipearch_dma_read_mc: bursts, alignment, round-robin, reorder, reset.
module tb_pipearch_dma_read_mc;
  localparam int NC = 4;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int LD = 6;
  localparam int CW = 2;
  localparam int TW = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NC-1:0]     cmd_valid, cmd_ready, cmd_multiline, out_valid, out_ready;
  logic [NC-1:0]     status_idle, status_done;
  logic [NC*AW-1:0]  cmd_addr;
  logic [NC*32-1:0]  cmd_length, cmd_stride;
  logic              mem_req_valid, mem_req_almfull, mem_rsp_valid;
  logic [AW-1:0]     mem_req_addr;
  logic [1:0]        mem_req_len, mem_rsp_cl_num;
  logic [TW-1:0]     mem_req_tag, mem_rsp_tag;
  logic [DW-1:0]     mem_rsp_data;
  logic [NC*DW-1:0]  out_data;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic [TW-1:0] tag;
  } req_t;

  req_t          req_q[$];
  logic [DW-1:0] out_q[NC][$];
  int            done_cnt[NC];
  int            outst[NC];
  int            max_outst[NC];

  pipearch_dma_read_mc #(
    .NUM_CHANNELS(NC), .ADDR_W(AW), .DATA_W(DW), .LOG2_DEPTH(LD), .CH_W(CW), .TAG_W(TW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_length(cmd_length), .cmd_stride(cmd_stride), .cmd_multiline(cmd_multiline),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
    .mem_req_tag(mem_req_tag), .mem_req_almfull(mem_req_almfull),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_cl_num(mem_rsp_cl_num),
    .mem_rsp_data(mem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .status_idle(status_idle), .status_done(status_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int lines_of(input logic [1:0] len);
    case (len)
      2'b01:   return 2;
      2'b11:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [DW-1:0] mk_data(input int c, input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d            = '0;
    d[AW-1:0]    = a;
    d[300 +: AW] = ~a;
    d[500 +: 8]  = 8'(c + 1);
    return d;
  endfunction

  // Monitor at the falling edge: request log, done pulses, popped lines, outstanding lines.
  always @(negedge clk) begin
    if (mem_req_valid) begin
      req_t r;
      r.addr = mem_req_addr;
      r.len  = mem_req_len;
      r.tag  = mem_req_tag;
      req_q.push_back(r);
      outst[int'(mem_req_tag[LD+CW-1:LD])] += lines_of(mem_req_len);
    end
    for (int c = 0; c < NC; c++) begin
      if (status_done[c]) done_cnt[c]++;
      if (out_valid[c] && out_ready[c]) begin
        out_q[c].push_back(out_data[c*DW +: DW]);
        outst[c]--;
      end
      if (outst[c] > max_outst[c]) max_outst[c] = outst[c];
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    req_q.delete();
    for (int c = 0; c < NC; c++) begin
      out_q[c].delete();
      done_cnt[c]  = 0;
      outst[c]     = 0;
      max_outst[c] = 0;
    end
  endtask

  task automatic drive_idle();
    cmd_valid = '0; cmd_addr = '0; cmd_length = '0; cmd_stride = '0; cmd_multiline = '0;
    out_ready = '0; mem_req_almfull = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_tag = '0;
    mem_rsp_cl_num = 2'b00; mem_rsp_data = '0;
  endtask

  task automatic reset_dut();
    drive_idle();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    clear_logs();
  endtask

  task automatic set_cmd(input int c, input logic [AW-1:0] a, input int len, input int stride,
                         input logic ml);
    cmd_valid[c]           = 1'b1;
    cmd_addr[c*AW +: AW]   = a;
    cmd_length[c*32 +: 32] = len;
    cmd_stride[c*32 +: 32] = stride;
    cmd_multiline[c]       = ml;
  endtask

  task automatic send_rsp(input logic [TW-1:0] tag, input logic [1:0] cl, input logic [DW-1:0] d);
    mem_rsp_valid  = 1'b1;
    mem_rsp_tag    = tag;
    mem_rsp_cl_num = cl;
    mem_rsp_data   = d;
    tick();
    mem_rsp_valid  = 1'b0;
  endtask

  // Answer every line of a request; the data encodes channel and line address.
  task automatic respond(input req_t r);
    for (int k = 0; k < lines_of(r.len); k++)
      send_rsp(r.tag, 2'(k), mk_data(int'(r.tag[LD+CW-1:LD]), r.addr + AW'(k)));
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int cyc = 0;
    while (req_q.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_outs(input int c, input int n, input int budget);
    int cyc = 0;
    while (out_q[c].size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while (status_idle !== '1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset_n = 1'b0;
    tick(2);
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b exp 0", mem_req_valid); else passed++;
    checks++; if (out_valid !== 4'h0) $display("FAIL reset_out_valid: got %0h exp 0", out_valid); else passed++;
    checks++; if (status_done !== 4'h0) $display("FAIL reset_done: got %0h exp 0", status_done); else passed++;
    checks++; if (cmd_ready !== 4'hf) $display("FAIL reset_cmd_ready: got %0h exp f", cmd_ready); else passed++;
    checks++; if (status_idle !== 4'hf) $display("FAIL reset_idle: got %0h exp f", status_idle); else passed++;
    reset_n = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic test_single_burst();
    reset_dut();
    set_cmd(0, 42'h100, 8, 1, 1'b1);
    tick();
    cmd_valid = '0;
    wait_reqs(2, 20);
    tick(5);
    checks++; if (req_q.size() != 2) $display("FAIL burst_req_count: got %0d exp 2", req_q.size()); else passed++;
    if (req_q.size() >= 2) begin
      checks++; if (req_q[0].addr !== 42'h100) $display("FAIL burst_addr0: got %0h exp 100", req_q[0].addr); else passed++;
      checks++; if (req_q[0].len !== 2'b11) $display("FAIL burst_len0: got %0b exp 11", req_q[0].len); else passed++;
      checks++; if (req_q[0].tag !== 16'h0) $display("FAIL burst_tag0: got %0h exp 0", req_q[0].tag); else passed++;
      checks++; if (req_q[1].addr !== 42'h104) $display("FAIL burst_addr1: got %0h exp 104", req_q[1].addr); else passed++;
      checks++; if (req_q[1].len !== 2'b11) $display("FAIL burst_len1: got %0b exp 11", req_q[1].len); else passed++;
      checks++; if (req_q[1].tag !== 16'h4) $display("FAIL burst_tag1: got %0h exp 4", req_q[1].tag); else passed++;
    end
    // Head line visible one cycle after its response; held while not ready.
    send_rsp(16'h0, 2'd0, mk_data(0, 42'h100));
    checks++; if (out_valid[0] !== 1'b1) $display("FAIL burst_head_latency: got %0b exp 1", out_valid[0]); else passed++;
    tick(2);
    checks++; if (out_data[DW-1:0] !== mk_data(0, 42'h100)) $display("FAIL burst_hold: got %0h exp %0h", out_data[AW-1:0], 42'h100); else passed++;
    out_ready = 4'h1;
    for (int k = 1; k < 4; k++) send_rsp(16'h0, 2'(k), mk_data(0, 42'h100 + AW'(k)));
    for (int k = 0; k < 4; k++) send_rsp(16'h4, 2'(k), mk_data(0, 42'h104 + AW'(k)));
    wait_outs(0, 8, 30);
    checks++; if (out_q[0].size() != 8) $display("FAIL burst_out_count: got %0d exp 8", out_q[0].size()); else passed++;
    for (int i = 0; i < out_q[0].size(); i++) begin
      checks++; if (out_q[0][i] !== mk_data(0, 42'h100 + AW'(i))) $display("FAIL burst_out_data[%0d]: got %0h exp %0h", i, out_q[0][i][AW-1:0], 42'h100 + i); else passed++;
    end
    wait_idle(20);
    checks++; if (done_cnt[0] != 1) $display("FAIL burst_done_once: got %0d exp 1", done_cnt[0]); else passed++;
    checks++; if (status_idle[0] !== 1'b1) $display("FAIL burst_idle_after: got %0b exp 1", status_idle[0]); else passed++;
  endtask

  task automatic test_unaligned();
    reset_dut();
    out_ready = 4'h1;
    set_cmd(0, 42'h101, 3, 1, 1'b1);
    tick();
    cmd_valid = '0;
    wait_reqs(2, 20);
    tick(5);
    checks++; if (req_q.size() != 2) $display("FAIL unal_req_count: got %0d exp 2", req_q.size()); else passed++;
    if (req_q.size() >= 2) begin
      checks++; if (req_q[0].addr !== 42'h101 || req_q[0].len !== 2'b00 || req_q[0].tag !== 16'h0) $display("FAIL unal_req0: got %0h/%0b/%0h exp 101/00/0", req_q[0].addr, req_q[0].len, req_q[0].tag); else passed++;
      checks++; if (req_q[1].addr !== 42'h102 || req_q[1].len !== 2'b01 || req_q[1].tag !== 16'h1) $display("FAIL unal_req1: got %0h/%0b/%0h exp 102/01/1", req_q[1].addr, req_q[1].len, req_q[1].tag); else passed++;
      respond(req_q[0]);
      respond(req_q[1]);
    end
    tick(10);
    checks++; if (out_q[0].size() != 3) $display("FAIL unal_out_count: got %0d exp 3", out_q[0].size()); else passed++;
    for (int i = 0; i < out_q[0].size(); i++) begin
      checks++; if (out_q[0][i] !== mk_data(0, 42'h101 + AW'(i))) $display("FAIL unal_out_data[%0d]: got %0h exp %0h", i, out_q[0][i][AW-1:0], 42'h101 + i); else passed++;
    end
    checks++; if (done_cnt[0] != 1) $display("FAIL unal_done: got %0d exp 1", done_cnt[0]); else passed++;
  endtask

  task automatic test_round_robin();
    int n0;
    req_t pend[$];
    reset_dut();
    for (int c = 0; c < NC; c++) set_cmd(c, AW'(32'h1000 * (c + 1)), 16, 2, 1'b1);
    tick();
    cmd_valid = '0;
    tick(6);
    mem_req_almfull = 1'b1;
    tick();
    n0 = req_q.size();
    tick(4);
    checks++; if (req_q.size() != n0) $display("FAIL rr_almfull: got %0d reqs exp %0d", req_q.size(), n0); else passed++;
    mem_req_almfull = 1'b0;
    wait_reqs(64, 100);
    tick(3);
    checks++; if (req_q.size() != 64) $display("FAIL rr_req_count: got %0d exp 64", req_q.size()); else passed++;
    for (int i = 0; i < req_q.size() && i < 64; i++) begin
      logic [AW-1:0] ea;
      logic [TW-1:0] et;
      ea = AW'(32'h1000 * (i % 4 + 1) + 2 * (i / 4));
      et = TW'((i % 4) * 64 + (i / 4));
      checks++; if (req_q[i].tag !== et) $display("FAIL rr_tag[%0d]: got %0h exp %0h", i, req_q[i].tag, et); else passed++;
      checks++; if (req_q[i].addr !== ea) $display("FAIL rr_addr[%0d]: got %0h exp %0h", i, req_q[i].addr, ea); else passed++;
      checks++; if (req_q[i].len !== 2'b00) $display("FAIL rr_len[%0d]: got %0b exp 00", i, req_q[i].len); else passed++;
    end
    out_ready = 4'hf;
    pend = req_q;
    req_q.delete();
    for (int i = 0; i < pend.size(); i++) respond(pend[i]);
    for (int c = 0; c < NC; c++) wait_outs(c, 16, 40);
    wait_idle(20);
    for (int c = 0; c < NC; c++) begin
      checks++; if (out_q[c].size() != 16) $display("FAIL rr_out_count[%0d]: got %0d exp 16", c, out_q[c].size()); else passed++;
      for (int k = 0; k < out_q[c].size(); k++) begin
        checks++; if (out_q[c][k] !== mk_data(c, AW'(32'h1000 * (c + 1) + 2 * k))) $display("FAIL rr_out_data[%0d][%0d]: got %0h", c, k, out_q[c][k][AW-1:0]); else passed++;
      end
      checks++; if (done_cnt[c] != 1) $display("FAIL rr_done[%0d]: got %0d exp 1", c, done_cnt[c]); else passed++;
    end
  endtask

  task automatic test_reverse_wrap();
    int cyc;
    req_t pend[$];
    reset_dut();
    set_cmd(0, 42'h2000, 100, 1, 1'b0);
    tick();
    cmd_valid = '0;
    wait_reqs(64, 100);
    tick(10);
    checks++; if (req_q.size() != 64) $display("FAIL rev_credit_stall: got %0d exp 64", req_q.size()); else passed++;
    pend = req_q;
    req_q.delete();
    for (int i = pend.size() - 1; i >= 0; i--) respond(pend[i]);
    tick(20);
    checks++; if (out_valid[0] !== 1'b1) $display("FAIL rev_head_valid: got %0b exp 1", out_valid[0]); else passed++;
    checks++; if (out_data[DW-1:0] !== mk_data(0, 42'h2000)) $display("FAIL rev_head_data: got %0h exp 2000", out_data[AW-1:0]); else passed++;
    checks++; if (req_q.size() != 0) $display("FAIL rev_no_extra_req: got %0d exp 0", req_q.size()); else passed++;
    out_ready = 4'h1;
    cyc = 0;
    while (out_q[0].size() < 100 && cyc < 1000) begin
      if (req_q.size() > 0) begin
        pend = req_q;
        req_q.delete();
        for (int i = pend.size() - 1; i >= 0; i--) respond(pend[i]);
        cyc += pend.size();
      end else begin
        tick();
        cyc++;
      end
    end
    wait_idle(20);
    checks++; if (out_q[0].size() != 100) $display("FAIL rev_out_count: got %0d exp 100", out_q[0].size()); else passed++;
    for (int i = 0; i < out_q[0].size(); i++) begin
      checks++; if (out_q[0][i] !== mk_data(0, 42'h2000 + AW'(i))) $display("FAIL rev_out_data[%0d]: got %0h exp %0h", i, out_q[0][i][AW-1:0], 42'h2000 + i); else passed++;
    end
    checks++; if (max_outst[0] != 64) $display("FAIL rev_max_outstanding: got %0d exp 64", max_outst[0]); else passed++;
    checks++; if (done_cnt[0] != 1) $display("FAIL rev_done: got %0d exp 1", done_cnt[0]); else passed++;
  endtask

  task automatic test_zero_length();
    reset_dut();
    set_cmd(1, 42'h500, 0, 1, 1'b0);
    checks++; if (status_done[1] !== 1'b0) $display("FAIL zero_done_early: got %0b exp 0", status_done[1]); else passed++;
    tick();
    cmd_valid = '0;
    // The accepting edge moves the channel straight to DONE.
    checks++; if (status_done[1] !== 1'b1) $display("FAIL zero_done_pulse: got %0b exp 1", status_done[1]); else passed++;
    checks++; if (cmd_ready[1] !== 1'b0) $display("FAIL zero_not_ready: got %0b exp 0", cmd_ready[1]); else passed++;
    tick();
    checks++; if (status_done[1] !== 1'b0) $display("FAIL zero_done_end: got %0b exp 0", status_done[1]); else passed++;
    checks++; if (status_idle[1] !== 1'b1) $display("FAIL zero_idle: got %0b exp 1", status_idle[1]); else passed++;
    tick(5);
    checks++; if (req_q.size() != 0) $display("FAIL zero_no_req: got %0d exp 0", req_q.size()); else passed++;
    checks++; if (done_cnt[1] != 1) $display("FAIL zero_done_count: got %0d exp 1", done_cnt[1]); else passed++;
  endtask

  task automatic test_reset_mid();
    req_t pend[$];
    reset_dut();
    set_cmd(0, 42'h3000, 20, 1, 1'b0);
    tick();
    cmd_valid = '0;
    wait_reqs(10, 30);
    pend = req_q;
    if (pend.size() > 0) respond(pend[0]);
    checks++; if (out_valid[0] !== 1'b1) $display("FAIL rmid_pre_valid: got %0b exp 1", out_valid[0]); else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL rmid_req_valid: got %0b exp 0", mem_req_valid); else passed++;
    checks++; if (out_valid !== 4'h0) $display("FAIL rmid_out_valid: got %0h exp 0", out_valid); else passed++;
    checks++; if (cmd_ready !== 4'hf) $display("FAIL rmid_cmd_ready: got %0h exp f", cmd_ready); else passed++;
    checks++; if (status_idle !== 4'hf) $display("FAIL rmid_idle: got %0h exp f", status_idle); else passed++;
    tick(2);
    reset_n = 1'b1;
    tick();
    clear_logs();
    for (int i = 1; i < pend.size(); i++) respond(pend[i]);
    tick(2);
    checks++; if (out_valid !== 4'h0) $display("FAIL rmid_late_dropped: got %0h exp 0", out_valid); else passed++;
    checks++; if (req_q.size() != 0) $display("FAIL rmid_no_req: got %0d exp 0", req_q.size()); else passed++;
    out_ready = 4'h1;
    set_cmd(0, 42'h400, 4, 1, 1'b1);
    tick();
    cmd_valid = '0;
    wait_reqs(1, 20);
    tick(3);
    checks++; if (req_q.size() != 1) $display("FAIL rmid_new_req_count: got %0d exp 1", req_q.size()); else passed++;
    if (req_q.size() >= 1) begin
      checks++; if (req_q[0].addr !== 42'h400 || req_q[0].len !== 2'b11 || req_q[0].tag !== 16'h0) $display("FAIL rmid_new_req: got %0h/%0b/%0h exp 400/11/0", req_q[0].addr, req_q[0].len, req_q[0].tag); else passed++;
      respond(req_q[0]);
    end
    wait_outs(0, 4, 20);
    wait_idle(20);
    checks++; if (out_q[0].size() != 4) $display("FAIL rmid_out_count: got %0d exp 4", out_q[0].size()); else passed++;
    for (int i = 0; i < out_q[0].size(); i++) begin
      checks++; if (out_q[0][i] !== mk_data(0, 42'h400 + AW'(i))) $display("FAIL rmid_out_data[%0d]: got %0h exp %0h", i, out_q[0][i][AW-1:0], 42'h400 + i); else passed++;
    end
    checks++; if (done_cnt[0] != 1) $display("FAIL rmid_done: got %0d exp 1", done_cnt[0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_unaligned();
    test_round_robin();
    test_reverse_wrap();
    test_zero_length();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
